// File: rtl/uart_frame_pkg.sv
// Shared constants, state encoding and write payload type for the framed-packet receiver.
package uart_frame_pkg;

  localparam logic [7:0] SYNC0 = 8'hA5;
  localparam logic [7:0] SYNC1 = 8'h5A;

  typedef enum logic [2:0] {
    S_SYNC0,
    S_SYNC1,
    S_LEN,
    S_LO,
    S_HI,
    S_CHK
  } state_e;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CHK  = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  typedef struct packed {
    logic [7:0] hi;
    logic [7:0] lo;
  } word_t;

endpackage

// File: rtl/uart_frame_timer.sv
// Reloadable inter-byte down-counter; pulses expired once the idle budget is used up while running.
module uart_frame_timer #(
  parameter int unsigned CYCLES = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic reload,
  input  logic run,
  output logic expired
);

  localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES + 1) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_expired;

  // A reload in the same cycle suppresses the pulse, so a late byte always wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= CW'(CYCLES);
      r_expired <= 1'b0;
    end else begin
      r_expired <= run && !reload && (r_cnt == CW'(1));
      if (reload || !run) begin
        r_cnt <= CW'(CYCLES);
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  assign expired = r_expired;

endmodule

// File: rtl/uart_frame_rx.sv
// Sync-locked frame decoder: A5 5A LEN, LEN little-endian words, XOR checksum.
// Define UART_FRAME_TIMEOUT_EN to abort stalled frames after TIMEOUT_US of silence.
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter int unsigned N          = 64,
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned TIMEOUT_US = 1000,
  parameter int unsigned AW         = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    byte_i,
  input  logic          byte_valid_i,
  output logic          wr_en_o,
  output logic [AW-1:0] wr_addr_o,
  output logic [15:0]   wr_data_o,
  output logic          frame_done_o,
  output logic          frame_err_o,
  output logic [1:0]    err_code_o,
  output logic          busy_o
);

  localparam int unsigned CW = 8;

  state_e        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [7:0]    r_xor, w_xor_nxt;
  logic [7:0]    r_lo, w_lo_nxt;
  logic          r_wr_en, w_wr_en_nxt;
  logic [AW-1:0] r_wr_addr, w_wr_addr_nxt;
  word_t         r_wr_data, w_wr_data_nxt;
  logic          r_done, w_done_nxt;
  logic          r_err, w_err_nxt;
  logic [1:0]    r_err_code, w_err_code_nxt;
  logic          r_busy;
  logic          w_tmo;

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int unsigned TMO_CYCLES = CLK_HZ / 1_000_000 * TIMEOUT_US;
  logic w_run;
  assign w_run = (r_state != S_SYNC0);

  uart_frame_timer #(
    .CYCLES (TMO_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .reload  (byte_valid_i),
    .run     (w_run),
    .expired (w_tmo)
  );
`else
  assign w_tmo = 1'b0;
`endif

  assign w_cnt_inc = r_cnt + CW'(1);

  // Next-state and registered-output logic; advances only on byte strobes.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_xor_nxt      = r_xor;
    w_lo_nxt       = r_lo;
    w_wr_en_nxt    = 1'b0;
    w_wr_addr_nxt  = r_wr_addr;
    w_wr_data_nxt  = r_wr_data;
    w_done_nxt     = 1'b0;
    w_err_nxt      = 1'b0;
    w_err_code_nxt = r_err_code;
    if (byte_valid_i) begin
      case (r_state)
        S_SYNC0: begin
          if (byte_i == SYNC0) w_state_nxt = S_SYNC1;
        end
        S_SYNC1: begin
          if (byte_i == SYNC1)      w_state_nxt = S_LEN;
          else if (byte_i != SYNC0) w_state_nxt = S_SYNC0;
        end
        S_LEN: begin
          if (byte_i == 8'(N)) begin
            w_state_nxt = S_LO;
            w_cnt_nxt   = '0;
            w_xor_nxt   = byte_i;
          end else begin
            w_state_nxt    = S_SYNC0;
            w_err_nxt      = 1'b1;
            w_err_code_nxt = ERR_LEN;
          end
        end
        S_LO: begin
          w_lo_nxt    = byte_i;
          w_xor_nxt   = r_xor ^ byte_i;
          w_state_nxt = S_HI;
        end
        S_HI: begin
          w_xor_nxt     = r_xor ^ byte_i;
          w_wr_en_nxt   = 1'b1;
          w_wr_addr_nxt = AW'(r_cnt);
          w_wr_data_nxt = '{hi: byte_i, lo: r_lo};
          w_cnt_nxt     = w_cnt_inc;
          w_state_nxt   = (w_cnt_inc == CW'(N)) ? S_CHK : S_LO;
        end
        S_CHK: begin
          w_state_nxt = S_SYNC0;
          if (byte_i == r_xor) begin
            w_done_nxt = 1'b1;
          end else begin
            w_err_nxt      = 1'b1;
            w_err_code_nxt = ERR_CHK;
          end
        end
        default: w_state_nxt = S_SYNC0;
      endcase
    end else if (w_tmo && (r_state != S_SYNC0)) begin
      w_state_nxt    = S_SYNC0;
      w_err_nxt      = 1'b1;
      w_err_code_nxt = ERR_TMO;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_SYNC0;
      r_cnt      <= '0;
      r_xor      <= '0;
      r_lo       <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_xor      <= w_xor_nxt;
      r_lo       <= w_lo_nxt;
      r_wr_en    <= w_wr_en_nxt;
      r_wr_addr  <= w_wr_addr_nxt;
      r_wr_data  <= w_wr_data_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_err_code <= w_err_code_nxt;
      r_busy     <= (w_state_nxt != S_SYNC0);
    end
  end

  assign wr_en_o      = r_wr_en;
  assign wr_addr_o    = r_wr_addr;
  assign wr_data_o    = r_wr_data;
  assign frame_done_o = r_done;
  assign frame_err_o  = r_err;
  assign err_code_o   = r_err_code;
  assign busy_o       = r_busy;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx: good/bad frames, resync, reset, back-to-back, optional timeout.
module tb_uart_frame_rx;

  localparam int unsigned N  = 64;
  localparam int unsigned AW = 6;
`ifdef UART_FRAME_TIMEOUT_EN
  localparam int unsigned TUS = 1;
`else
  localparam int unsigned TUS = 1000;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    byte_i = 8'h00;
  logic          byte_valid_i = 1'b0;
  logic          wr_en_o;
  logic [AW-1:0] wr_addr_o;
  logic [15:0]   wr_data_o;
  logic          frame_done_o;
  logic          frame_err_o;
  logic [1:0]    err_code_o;
  logic          busy_o;

  uart_frame_rx #(
    .N          (N),
    .CLK_HZ     (100_000_000),
    .TIMEOUT_US (TUS),
    .AW         (AW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .wr_en_o      (wr_en_o),
    .wr_addr_o    (wr_addr_o),
    .wr_data_o    (wr_data_o),
    .frame_done_o (frame_done_o),
    .frame_err_o  (frame_err_o),
    .err_code_o   (err_code_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int n_wr = 0;
  int n_done = 0;
  int n_ferr = 0;
  int n_both = 0;
  logic [AW-1:0] log_addr [0:1023];
  logic [15:0]   log_data [0:1023];

  // Output monitor on the falling edge.
  always @(negedge clk) begin
    if (wr_en_o) begin
      if (n_wr < 1024) begin
        log_addr[n_wr] = wr_addr_o;
        log_data[n_wr] = wr_data_o;
      end
      n_wr++;
    end
    if (frame_done_o) n_done++;
    if (frame_err_o) n_ferr++;
    if (frame_done_o && frame_err_o) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_i       = b;
    byte_valid_i = 1'b1;
    @(posedge clk);
    #1;
    byte_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_hdr();
    send_byte(8'hA5);
    send_byte(8'h5A);
    send_byte(8'h40);
  endtask

  // Word k: LO = k, HI = k or 0. Either way the XOR over LEN and payload is 0x40.
  task automatic send_payload(input int nwords, input bit hi_k);
    for (int k = 0; k < nwords; k++) begin
      send_byte(8'(k));
      send_byte(hi_k ? 8'(k) : 8'h00);
    end
  endtask

  task automatic check_writes(input string tag, input int base, input bit hi_k);
    check({tag, "_wr_count"}, 32'(n_wr - base), 32'd64);
    for (int i = 0; i < 64; i++) begin
      check({tag, "_addr"}, 32'(log_addr[base + i]), 32'(i));
      check({tag, "_data"}, 32'(log_data[base + i]), hi_k ? 32'((i << 8) | i) : 32'(i));
    end
  endtask

  int base, d0, e0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_en", 32'(wr_en_o), 32'd0);
    check("rst_done", 32'(frame_done_o), 32'd0);
    check("rst_err", 32'(frame_err_o), 32'd0);
    check("rst_code", 32'(err_code_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_addr_data", 32'({wr_addr_o, wr_data_o}), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Good frame, HI = 0.
    base = n_wr; d0 = n_done; e0 = n_ferr;
    send_hdr();
    check("good_busy", 32'(busy_o), 32'd1);
    send_payload(64, 1'b0);
    send_byte(8'h40);
    check("good_done_pulse", 32'(frame_done_o), 32'd1);
    check("good_err_pulse", 32'(frame_err_o), 32'd0);
    idle(2);
    check_writes("good", base, 1'b0);
    check("good_done_cnt", 32'(n_done - d0), 32'd1);
    check("good_err_cnt", 32'(n_ferr - e0), 32'd0);
    check("good_busy_end", 32'(busy_o), 32'd0);

    // Bad checksum.
    base = n_wr; d0 = n_done; e0 = n_ferr;
    send_hdr();
    send_payload(64, 1'b0);
    send_byte(8'h41);
    check("badchk_err_pulse", 32'(frame_err_o), 32'd1);
    check("badchk_code", 32'(err_code_o), 32'd2);
    check("badchk_done_pulse", 32'(frame_done_o), 32'd0);
    idle(2);
    check("badchk_wr_count", 32'(n_wr - base), 32'd64);
    check("badchk_done_cnt", 32'(n_done - d0), 32'd0);
    check("badchk_err_cnt", 32'(n_ferr - e0), 32'd1);

    // Bad length.
    base = n_wr; d0 = n_done; e0 = n_ferr;
    send_byte(8'hA5);
    send_byte(8'h5A);
    check("badlen_busy_before", 32'(busy_o), 32'd1);
    send_byte(8'h3F);
    check("badlen_err_pulse", 32'(frame_err_o), 32'd1);
    check("badlen_code", 32'(err_code_o), 32'd1);
    check("badlen_busy_after", 32'(busy_o), 32'd0);
    idle(2);
    check("badlen_wr_count", 32'(n_wr - base), 32'd0);
    check("badlen_err_cnt", 32'(n_ferr - e0), 32'd1);

    // Garbage then A5 A5 5A resync, HI = k.
    base = n_wr; d0 = n_done;
    send_byte(8'h00);
    send_byte(8'hA5);
    send_hdr();
    send_payload(64, 1'b1);
    send_byte(8'h40);
    check("resync_done_pulse", 32'(frame_done_o), 32'd1);
    idle(2);
    check_writes("resync", base, 1'b1);
    check("resync_done_cnt", 32'(n_done - d0), 32'd1);

    // A5 13 drops silently, code from the last error is held.
    e0 = n_ferr;
    send_byte(8'hA5);
    send_byte(8'h13);
    check("garbage_busy", 32'(busy_o), 32'd0);
    idle(2);
    check("garbage_err_cnt", 32'(n_ferr - e0), 32'd0);
    check("garbage_code_held", 32'(err_code_o), 32'd1);
    d0 = n_done;
    send_hdr();
    send_payload(64, 1'b0);
    send_byte(8'h40);
    idle(2);
    check("after_garbage_done_cnt", 32'(n_done - d0), 32'd1);

    // Reset at word 20.
    d0 = n_done; e0 = n_ferr;
    send_hdr();
    send_payload(20, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", 32'({wr_en_o, frame_done_o, frame_err_o, err_code_o, busy_o}), 32'd0);
    idle(3);
    rst_n = 1'b1;
    idle(3);
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_code", 32'(err_code_o), 32'd0);
    check("midrst_no_pulse", 32'((n_done - d0) + (n_ferr - e0)), 32'd0);

    // Two frames with no gap.
    base = n_wr; d0 = n_done; e0 = n_ferr;
    send_hdr();
    send_payload(64, 1'b1);
    send_byte(8'h40);
    send_hdr();
    send_payload(64, 1'b0);
    send_byte(8'h40);
    idle(2);
    check("b2b_done_cnt", 32'(n_done - d0), 32'd2);
    check("b2b_err_cnt", 32'(n_ferr - e0), 32'd0);
    check("b2b_wr_count", 32'(n_wr - base), 32'd128);

`ifdef UART_FRAME_TIMEOUT_EN
    begin
      int waited;
      bit seen;
      e0 = n_ferr;
      seen = 1'b0;
      waited = 0;
      send_hdr();
      send_payload(5, 1'b0);
      while (!seen && waited < 300) begin
        idle(1);
        waited++;
        if (frame_err_o) seen = 1'b1;
      end
      check("tmo_seen", 32'(seen), 32'd1);
      check("tmo_code", 32'(err_code_o), 32'd3);
      check("tmo_window", 32'(waited >= 95 && waited <= 110), 32'd1);
      check("tmo_busy", 32'(busy_o), 32'd0);
      d0 = n_done;
      send_hdr();
      send_payload(64, 1'b0);
      send_byte(8'h40);
      idle(2);
      check("tmo_next_done_cnt", 32'(n_done - d0), 32'd1);
    end
`endif

    check("never_both_pulses", 32'(n_both), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
